// File: rtl/maze_link_tx_if.sv
// Request handshake plus the 9-wire maze-update bus of the link transmitter.
// The requester uses the master modport; the transmitter uses the slave modport.
interface maze_link_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_done;
  logic [4:0] req_addr;
  logic [8:0] req_cell;
  logic       link_clk;
  logic [4:0] link_addr;
  logic [2:0] link_data;

  modport master (
    output req_valid, req_done, req_addr, req_cell,
    input  req_ready, link_clk, link_addr, link_data
  );

  modport slave (
    input  req_valid, req_done, req_addr, req_cell,
    output req_ready, link_clk, link_addr, link_data
  );
endinterface

// File: rtl/maze_link_tx.sv
// Maze-update link transmitter: turns cell-update / maze-done requests into
// sync-framed beats on a self-generated slow strobe. Every output is a
// register loaded from the next-state view, so the bus changes only at edges.
module maze_link_tx #(
  parameter int HALF_PERIOD = 25
) (
  input  logic            CLOCK_25,
  input  logic            reset,
  maze_link_tx_if.slave   bus,
  output logic            busy,
  output logic            err_addr,
  output logic [15:0]     frames_sent
);

  localparam int CW = $clog2(HALF_PERIOD) + 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_BEAT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    beat_r, beat_s;
  logic          done_r, done_s;
  logic [4:0]    addr_r, addr_s;
  logic [8:0]    cell_r, cell_s;
  logic          err_s;
  logic          frame_end_s;
  logic          lclk_s;
  logic [4:0]    laddr_s;
  logic [2:0]    ldata_s;

  logic          ready_r;
  logic          busy_r;
  logic          err_r;
  logic [15:0]   frames_r;
  logic          lclk_r;
  logic [4:0]    laddr_r;
  logic [2:0]    ldata_r;

  assign bus.req_ready = ready_r;
  assign bus.link_clk  = lclk_r;
  assign bus.link_addr = laddr_r;
  assign bus.link_data = ldata_r;
  assign busy          = busy_r;
  assign err_addr      = err_r;
  assign frames_sent   = frames_r;

  // Next state, beat sequencing and the bus values the next cycle will show.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    beat_s      = beat_r;
    done_s      = done_r;
    addr_s      = addr_r;
    cell_s      = cell_r;
    err_s       = 1'b0;
    frame_end_s = 1'b0;
    lclk_s      = 1'b0;
    laddr_s     = 5'd31;
    ldata_s     = 3'd0;

    case (state_r)
      ST_IDLE: begin
        cnt_s  = '0;
        beat_s = 3'd0;
        if (bus.req_valid && ready_r) begin
          if (bus.req_done) begin
            done_s  = 1'b1;
            state_s = ST_SYNC;
          end else if (bus.req_addr <= 5'd29) begin
            done_s  = 1'b0;
            addr_s  = bus.req_addr;
            cell_s  = bus.req_cell;
            state_s = ST_SYNC;
          end else begin
            // Reserved address: drop the request and flag it.
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = '0;
          if (done_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_BEAT;
            beat_s  = 3'd0;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_BEAT: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = '0;
          if (beat_r == 3'd4) begin
            state_s     = ST_IDLE;
            beat_s      = 3'd0;
            frame_end_s = 1'b1;
          end else begin
            beat_s = beat_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_DONE: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s       = '0;
          state_s     = ST_IDLE;
          frame_end_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        beat_s  = 3'd0;
      end
    endcase

    // Strobe is low for the first half of each beat, high for the second.
    lclk_s = (state_s != ST_IDLE) && (cnt_s >= CNT_HALF);

    case (state_s)
      ST_IDLE: begin
        laddr_s = 5'd31;
        ldata_s = 3'd0;
      end
      ST_SYNC: begin
        laddr_s = 5'd31;
        ldata_s = 3'd0;
      end
      ST_DONE: begin
        laddr_s = 5'd30;
        ldata_s = 3'd0;
      end
      ST_BEAT: begin
        laddr_s = addr_s;
        case (beat_s)
          3'd1:    ldata_s = cell_s[2:0];
          3'd2:    ldata_s = cell_s[5:3];
          3'd3:    ldata_s = cell_s[8:6];
          default: ldata_s = 3'd0;
        endcase
      end
      default: begin
        laddr_s = 5'd31;
        ldata_s = 3'd0;
      end
    endcase
  end

  // State, latched request and registered outputs; reset aborts any frame.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      beat_r   <= 3'd0;
      done_r   <= 1'b0;
      addr_r   <= 5'd0;
      cell_r   <= 9'd0;
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
      frames_r <= 16'd0;
      lclk_r   <= 1'b0;
      laddr_r  <= 5'd31;
      ldata_r  <= 3'd0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      beat_r   <= beat_s;
      done_r   <= done_s;
      addr_r   <= addr_s;
      cell_r   <= cell_s;
      ready_r  <= (state_s == ST_IDLE);
      busy_r   <= (state_s != ST_IDLE);
      err_r    <= err_s;
      if (frame_end_s) begin
        frames_r <= frames_r + 16'd1;
      end else begin
        frames_r <= frames_r;
      end
      lclk_r   <= lclk_s;
      laddr_r  <= laddr_s;
      ldata_r  <= ldata_s;
    end
  end

endmodule
